// File: rtl/stream_capture_pkg.sv
// Shared types and defaults for the stream capture block.
//   state_t    : capture FSM states
//   *_DEF      : default widths for DATA_W / ADDR_W / DECIM_W
//   depth_of() : RAM depth for a given address width
package stream_capture_pkg;

  localparam int unsigned DATA_W_DEF  = 32;
  localparam int unsigned ADDR_W_DEF  = 10;
  localparam int unsigned DECIM_W_DEF = 8;

  function automatic int unsigned depth_of(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

  localparam int unsigned DEPTH = depth_of(ADDR_W_DEF);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    READOUT = 2'd3
  } state_t;

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port sample RAM: one write port, one registered read port
// (1-cycle latency). Written to infer block RAM; no reset on the array.
//   clk       : clock
//   i_wr_en   : write enable
//   i_wr_addr : write address
//   i_wr_data : write data
//   i_rd_en   : read enable (updates o_rd_data on the next edge)
//   i_rd_addr : read address
//   o_rd_data : registered read data
module capture_ram
  import stream_capture_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  localparam int unsigned L_DEPTH = depth_of(ADDR_W);

  logic [DATA_W-1:0] r_mem [0:L_DEPTH-1];
  logic [DATA_W-1:0] r_rd_data;

  // Write port and registered read port
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
    if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/stream_capture.sv
// Triggered burst capture of a sample stream into RAM, followed by replay
// over a valid/ready interface.
// Optional feature: define STREAM_CAPTURE_DECIM_EN to enable decimation
// (keep 1 of decim+1 valid samples after the trigger sample).
//   clk, reset : clock, synchronous active-high reset
//   s_data     : input sample       s_valid : input qualifier (no backpressure)
//   arm        : start pulse        trig    : level trigger, qualified by s_valid
//   len        : burst length, 0 means 2^ADDR_W
//   decim      : decimation ratio - 1 (used only with STREAM_CAPTURE_DECIM_EN)
//   m_data / m_valid / m_ready / m_last : readout stream
//   busy       : high while armed, capturing or replaying
//   done       : one-cycle pulse after the last readout beat is accepted
module stream_capture
  import stream_capture_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DECIM_W = DECIM_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [DATA_W-1:0]  s_data,
  input  logic               s_valid,
  input  logic               arm,
  input  logic               trig,
  input  logic [ADDR_W:0]    len,
  input  logic [DECIM_W-1:0] decim,
  output logic [DATA_W-1:0]  m_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic               m_last,
  output logic               busy,
  output logic               done
);

  localparam int unsigned LEN_W   = ADDR_W + 1;
  localparam int unsigned L_DEPTH = depth_of(ADDR_W);

  state_t r_state;
  state_t w_next;

  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_wptr;
  logic [LEN_W-1:0]  r_rptr;

  logic              r_m_valid;
  logic              r_m_last;
  logic [DATA_W-1:0] r_m_data;
  logic              r_skid_valid;
  logic              r_skid_last;
  logic [DATA_W-1:0] r_skid_data;
  logic              r_inflight;
  logic              r_inflight_last;
  logic              r_busy;
  logic              r_done;

  logic              w_accept;
  logic              w_trig_hit;
  logic              w_wr_en;
  logic [ADDR_W-1:0] w_wr_addr;
  logic              w_pop;
  logic              w_last_pop;
  logic              w_out_free;
  logic [1:0]        w_occ;
  logic              w_rd_en;
  logic              w_rd_last;
  logic [DATA_W-1:0] w_rd_data;

`ifdef STREAM_CAPTURE_DECIM_EN
  logic [DECIM_W-1:0] r_decim;
  logic [DECIM_W-1:0] r_dcnt;
  logic               w_dcnt_hit;

  assign w_dcnt_hit = (r_dcnt == r_decim);
  assign w_accept   = s_valid && w_dcnt_hit;

  // Decimation counter: cleared by the trigger sample, wraps at decim
  always_ff @(posedge clk) begin
    if (reset) begin
      r_decim <= '0;
      r_dcnt  <= '0;
    end else begin
      if ((r_state == IDLE) && arm) begin
        r_decim <= decim;
      end
      if (w_trig_hit) begin
        r_dcnt <= '0;
      end else if ((r_state == CAPTURE) && s_valid) begin
        r_dcnt <= w_dcnt_hit ? '0 : r_dcnt + DECIM_W'(1);
      end
    end
  end
`else
  logic w_decim_unused;
  assign w_decim_unused = ^decim;
  assign w_accept       = s_valid;
`endif

  // Readout side: output register plus one skid entry; a read is issued only
  // when its data is guaranteed a slot (occupancy counts in-flight reads).
  assign w_pop      = r_m_valid && m_ready;
  assign w_last_pop = w_pop && r_m_last;
  assign w_out_free = !r_m_valid || m_ready;
  assign w_occ      = {1'b0, r_m_valid} + {1'b0, r_skid_valid} + {1'b0, r_inflight};
  assign w_rd_en    = (r_state == READOUT) && (r_rptr < r_len) &&
                      ((w_occ - {1'b0, w_pop}) < 2'd2);
  assign w_rd_last  = (r_rptr == r_len - LEN_W'(1));

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and write-port control
  always_comb begin
    w_next     = r_state;
    w_trig_hit = 1'b0;
    w_wr_en    = 1'b0;
    w_wr_addr  = '0;
    case (r_state)
      IDLE: begin
        if (arm) begin
          w_next = ARMED;
        end
      end
      ARMED: begin
        if (s_valid && trig) begin
          w_trig_hit = 1'b1;
          w_wr_en    = 1'b1;
          w_wr_addr  = '0;
          w_next     = (r_len == LEN_W'(1)) ? READOUT : CAPTURE;
        end
      end
      CAPTURE: begin
        if (w_accept) begin
          w_wr_en   = 1'b1;
          w_wr_addr = r_wptr[ADDR_W-1:0];
          if ((r_wptr + LEN_W'(1)) == r_len) begin
            w_next = READOUT;
          end
        end
      end
      READOUT: begin
        if (w_last_pop) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Length latch and pointers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_len  <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if ((r_state == IDLE) && arm) begin
        r_len <= (len == '0) ? LEN_W'(L_DEPTH) : len;
      end
      if (w_trig_hit) begin
        r_wptr <= LEN_W'(1);
      end else if ((r_state == CAPTURE) && w_accept) begin
        r_wptr <= r_wptr + LEN_W'(1);
      end
      if (r_state != READOUT) begin
        r_rptr <= '0;
      end else if (w_rd_en) begin
        r_rptr <= r_rptr + LEN_W'(1);
      end
    end
  end

  // Read pipeline, skid entry and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_m_valid       <= 1'b0;
      r_m_last        <= 1'b0;
      r_m_data        <= '0;
      r_skid_valid    <= 1'b0;
      r_skid_last     <= 1'b0;
      r_skid_data     <= '0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
    end else begin
      r_inflight      <= w_rd_en;
      r_inflight_last <= w_rd_last;
      if (w_out_free) begin
        if (r_skid_valid) begin
          r_m_valid    <= 1'b1;
          r_m_data     <= r_skid_data;
          r_m_last     <= r_skid_last;
          r_skid_valid <= r_inflight;
          if (r_inflight) begin
            r_skid_data <= w_rd_data;
            r_skid_last <= r_inflight_last;
          end
        end else if (r_inflight) begin
          r_m_valid <= 1'b1;
          r_m_data  <= w_rd_data;
          r_m_last  <= r_inflight_last;
        end else begin
          r_m_valid <= 1'b0;
          r_m_last  <= 1'b0;
        end
      end else if (r_inflight) begin
        r_skid_valid <= 1'b1;
        r_skid_data  <= w_rd_data;
        r_skid_last  <= r_inflight_last;
      end
      r_busy <= (w_next != IDLE);
      r_done <= w_last_pop;
    end
  end

  capture_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk       (clk),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (w_wr_addr),
    .i_wr_data (s_data),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (r_rptr[ADDR_W-1:0]),
    .o_rd_data (w_rd_data)
  );

  assign m_data  = r_m_data;
  assign m_valid = r_m_valid;
  assign m_last  = r_m_last;
  assign busy    = r_busy;
  assign done    = r_done;

endmodule

// File: tb/tb_stream_capture.sv
// Directed self-checking bench for stream_capture (ADDR_W=4 so that a
// full-depth burst is 16 samples). Define STREAM_CAPTURE_DECIM_EN for both
// bench and RTL to include the decimation scenario.
module tb_stream_capture;

  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 4;
  localparam int unsigned DCW = 8;

  logic           clk     = 1'b0;
  logic           reset   = 1'b1;
  logic [DW-1:0]  s_data  = '0;
  logic           s_valid = 1'b0;
  logic           arm     = 1'b0;
  logic           trig    = 1'b0;
  logic [AW:0]    len     = '0;
  logic [DCW-1:0] decim   = '0;
  logic           m_ready = 1'b0;
  logic [DW-1:0]  m_data;
  logic           m_valid;
  logic           m_last;
  logic           busy;
  logic           done;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  stream_capture #(
    .DATA_W  (DW),
    .ADDR_W  (AW),
    .DECIM_W (DCW)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .s_data  (s_data),
    .s_valid (s_valid),
    .arm     (arm),
    .trig    (trig),
    .len     (len),
    .decim   (decim),
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_last  (m_last),
    .busy    (busy),
    .done    (done)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_arm(input logic [AW:0] l);
    len = l;
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  // Drive count cycles of s_data=first+k; trig high from trig_at on;
  // gap=1 makes s_valid alternate 1,0,1,0...
  task automatic run_samples(input int first, input int count, input int trig_at, input bit gap);
    for (int k = 0; k < count; k++) begin
      s_data  = DW'(first + k);
      s_valid = gap ? ((k % 2) == 0) : 1'b1;
      trig    = ((first + k) >= trig_at);
      tick();
    end
    s_valid = 1'b0;
    trig    = 1'b0;
  endtask

  // Accept n beats expecting first, first+step, ...; pattern 0 = always
  // ready, pattern 1 = ready 1,0,0,1,0,0...; checks stall stability and done.
  task automatic collect(input string tag, input int n, input int first, input int step, input int pattern);
    int          got;
    int          cyc;
    logic        held_v;
    logic [31:0] held_d;
    got    = 0;
    cyc    = 0;
    held_v = 1'b0;
    held_d = '0;
    while ((got < n) && (cyc < 200)) begin
      m_ready = (pattern == 0) ? 1'b1 : ((cyc % 3) == 0);
      if (held_v) begin
        check({tag, " stall valid"}, 32'(m_valid), 32'd1);
        check({tag, " stall data"}, m_data, held_d);
      end
      held_v = m_valid && !m_ready;
      held_d = m_data;
      if (m_valid && m_ready) begin
        check({tag, " data"}, m_data, 32'(first + got * step));
        check({tag, " last"}, 32'(m_last), 32'(got == n - 1));
        got++;
      end
      tick();
      cyc++;
    end
    m_ready = 1'b0;
    check({tag, " beat count"}, 32'(got), 32'(n));
    check({tag, " done pulse"}, 32'(done), 32'd1);
    check({tag, " busy after"}, 32'(busy), 32'd0);
    check({tag, " valid after"}, 32'(m_valid), 32'd0);
    tick();
    check({tag, " done cleared"}, 32'(done), 32'd0);
  endtask

  initial begin
    // Reset state
    reset = 1'b1;
    tick();
    tick();
    check("rst m_valid", 32'(m_valid), 32'd0);
    check("rst m_last", 32'(m_last), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst m_data", m_data, 32'd0);
    reset = 1'b0;
    tick();

    // Basic: len=4, trigger at 103; len input changed after arm must not matter
    do_arm(5'd4);
    check("basic busy armed", 32'(busy), 32'd1);
    len = 5'd9;
    run_samples(100, 7, 103, 1'b0);
    check("basic lat0", 32'(m_valid), 32'd0);
    tick();
    check("basic lat1", 32'(m_valid), 32'd0);
    tick();
    check("basic lat2 valid", 32'(m_valid), 32'd1);
    check("basic lat2 data", m_data, 32'd103);
    collect("basic", 4, 103, 1, 0);

    // Backpressure: len=8, ready 1,0,0,1,...
    do_arm(5'd8);
    run_samples(200, 8, 200, 1'b0);
    collect("bp", 8, 200, 1, 1);

    // Input gaps: only valid samples are captured
    do_arm(5'd4);
    run_samples(300, 10, 300, 1'b1);
    collect("gap", 4, 300, 2, 0);

    // len=1: trigger sample only
    do_arm(5'd1);
    run_samples(400, 1, 400, 1'b0);
    collect("len1", 1, 400, 1, 0);

    // len=0 means full depth (16)
    do_arm(5'd0);
    run_samples(500, 20, 500, 1'b0);
    collect("len0", 16, 500, 1, 1);

    // Reset mid-capture after 3 samples
    do_arm(5'd8);
    run_samples(600, 3, 600, 1'b0);
    check("abort busy before", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort busy", 32'(busy), 32'd0);
    check("abort m_valid", 32'(m_valid), 32'd0);
    check("abort done", 32'(done), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("abort no done", 32'(done), 32'd0);
    end
    do_arm(5'd2);
    run_samples(700, 2, 700, 1'b0);
    collect("rearm", 2, 700, 1, 0);

`ifdef STREAM_CAPTURE_DECIM_EN
    // decim=2 latched on arm: trigger at 10 keeps 10,13,16,19
    decim = 8'd2;
    do_arm(5'd4);
    decim = 8'd0;
    run_samples(0, 25, 10, 1'b0);
    collect("decim", 4, 10, 3, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
